// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers bytes and error flags from the UART receiver for host pop (opt. UART_RX_FIFO_ALMOST_FULL_EN).
// Latency: rx_valid seen at edge E0 -> entry written at E2; pop data registered one edge after rd_en.
// Backpressure: none toward the receiver; a byte arriving while full is dropped and flagged in overflow.
module uart_rx_fifo #(
   parameter int DEPTH = 16
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,parameter int AF_LEVEL = DEPTH - 2
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_parity_err,
   input  logic                     rx_stop_err,
   input  logic                     rx_valid,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     rd_parity_err,
   output logic                     rd_stop_err,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_ovf,
   output logic [7:0]               err_cnt
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,output logic                     almost_full
`endif
);

   localparam int ADDR_W = $clog2(DEPTH);

   typedef struct packed {
      logic       stop_err;
      logic       parity_err;
      logic [7:0] data;
   } entry_t;

   entry_t              mem [DEPTH];
   logic [ADDR_W-1:0]   wptr;
   logic [ADDR_W-1:0]   rptr;
   logic                s1, s2, s3;
   logic                push;
   logic                pop_ok;
   logic                push_ok;
   logic                drop;
   logic                err_any;
   logic [ADDR_W:0]     count_nxt;

   // Edge-detect the synchronized level so a long rx_valid yields one push.
   assign push    = s2 & ~s3;
   assign empty   = (count == '0);
   assign full    = (count == (ADDR_W+1)'(DEPTH));
   assign pop_ok  = rd_en & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign drop    = push & full & ~pop_ok;
   assign err_any = rx_parity_err | rx_stop_err;

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + (ADDR_W+1)'(1);
      else if (!push_ok && pop_ok)
         count_nxt = count - (ADDR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         s3            <= 1'b0;
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         rd_data       <= '0;
         rd_parity_err <= 1'b0;
         rd_stop_err   <= 1'b0;
         rd_valid      <= 1'b0;
         overflow      <= 1'b0;
         err_cnt       <= '0;
      end else begin
         s1       <= rx_valid;
         s2       <= s1;
         s3       <= s2;
         count    <= count_nxt;
         rd_valid <= pop_ok;
         if (push_ok)
            wptr <= wptr + ADDR_W'(1);
         if (pop_ok) begin
            rptr          <= rptr + ADDR_W'(1);
            rd_data       <= mem[rptr].data;
            rd_parity_err <= mem[rptr].parity_err;
            rd_stop_err   <= mem[rptr].stop_err;
         end
         // A drop in the same cycle as clr_ovf must leave the flag set.
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
         if (push_ok && err_any && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

   // Storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr] <= '{stop_err: rx_stop_err, parity_err: rx_parity_err, data: rx_data};
   end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);

   always_ff @(posedge clk) begin
      if (!rst)
         almost_full <= 1'b0;
      else
         almost_full <= (count_nxt >= AF_THR);
   end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a scoreboard queue of expected popped entries.
module tb_uart_rx_fifo;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_parity_err;
   logic       rx_stop_err;
   logic       rx_valid;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_parity_err;
   logic       rd_stop_err;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       clr_ovf;
   logic [7:0] err_cnt;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   logic       almost_full;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [9:0] sb [$];

   uart_rx_fifo #(.DEPTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_parity_err (rx_parity_err),
      .rx_stop_err   (rx_stop_err),
      .rx_valid      (rx_valid),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_parity_err (rd_parity_err),
      .rd_stop_err   (rd_stop_err),
      .rd_valid      (rd_valid),
      .empty         (empty),
      .full          (full),
      .count         (count),
      .overflow      (overflow),
      .clr_ovf       (clr_ovf),
      .err_cnt       (err_cnt)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
     ,.almost_full   (almost_full)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte for 'hold' cycles, then idle long enough for the edge detector to re-arm.
   task automatic send_byte(input logic [7:0] d, input logic pe, input logic se,
                            input int hold, input bit accepted);
      rx_data       = d;
      rx_parity_err = pe;
      rx_stop_err   = se;
      rx_valid      = 1'b1;
      repeat (hold) tick();
      rx_valid = 1'b0;
      repeat (3) tick();
      if (accepted) sb.push_back({se, pe, d});
   endtask

   task automatic compare_pop(input string tag);
      logic [9:0] exp;
      vectors++;
      assert (sb.size() > 0) else begin
         miscompares++;
         $error("FAIL %s_sb: observed pop with %0d queued expected at least 1", tag, sb.size());
      end
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         check(tag, {22'd0, rd_stop_err, rd_parity_err, rd_data}, {22'd0, exp});
      end
   endtask

   task automatic pop_one(input string tag);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check({tag, "_vld"}, rd_valid, 1'b1);
      compare_pop(tag);
      tick();
      check({tag, "_vld_pulse"}, rd_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b0; rx_data = '0; rx_parity_err = 0; rx_stop_err = 0;
      rx_valid = 0; rd_en = 0; clr_ovf = 0;

      // Reset
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_count", count, 0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_errcnt", err_cnt, 0);
      check("rst_rdvalid", rd_valid, 1'b0);
      check("rst_rddata", rd_data, 0);

      // Single byte held high for 100 cycles, with latency probe
      rx_data = 8'h4D; rx_valid = 1'b1;
      tick(); tick();
      check("lat_e1_empty", empty, 1'b1);
      tick();
      check("lat_e2_count", count, 1);
      check("lat_e2_empty", empty, 1'b0);
      repeat (97) tick();
      rx_valid = 1'b0;
      repeat (3) tick();
      sb.push_back({2'b00, 8'h4D});
      check("single_count", count, 1);
      pop_one("single_pop");
      check("single_empty", empty, 1'b1);

      // Error-flagged bytes
      send_byte(8'hB3, 1'b1, 1'b0, 4, 1'b1);
      send_byte(8'h11, 1'b0, 1'b1, 4, 1'b1);
      check("err_cnt2", err_cnt, 2);
      pop_one("err_pop_b3");
      pop_one("err_pop_11");

      // Pop while empty is ignored; rd_data holds
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check("empty_pop_vld", rd_valid, 1'b0);
      check("empty_pop_count", count, 0);
      check("empty_pop_hold", rd_data, 8'h11);

      // Fill to full, then overflow
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0, 4, 1'b1);
      check("fill_full", full, 1'b1);
      check("fill_count", count, 16);
      send_byte(8'hAA, 1'b0, 1'b0, 4, 1'b0);
      check("ovf_set", overflow, 1'b1);
      check("ovf_count", count, 16);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("ovf_clr", overflow, 1'b0);

      // Push and pop on the same edge while full
      rx_data = 8'h55; rx_valid = 1'b1;
      tick(); tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("simfull_vld", rd_valid, 1'b1);
      compare_pop("simfull_pop");
      check("simfull_count", count, 16);
      check("simfull_noovf", overflow, 1'b0);
      sb.push_back({2'b00, 8'h55});
      rx_valid = 1'b0;
      repeat (3) tick();

      // Drop coinciding with clr_ovf: set wins
      rx_data = 8'hBB; rx_valid = 1'b1; clr_ovf = 1'b1;
      tick(); tick(); tick();
      clr_ovf = 1'b0; rx_valid = 1'b0;
      check("setwins_ovf", overflow, 1'b1);
      check("setwins_count", count, 16);
      repeat (3) tick();

      // Drain through the wrap point
      for (int i = 0; i < 16; i++) pop_one("drain");
      check("drain_empty", empty, 1'b1);
      check("drain_ovf_sticky", overflow, 1'b1);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("drain_ovf_clr", overflow, 1'b0);

      // Push and pop on the same edge while empty: pop ignored
      rx_data = 8'h77; rx_valid = 1'b1;
      tick(); tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("simempty_vld", rd_valid, 1'b0);
      check("simempty_count", count, 1);
      sb.push_back({2'b00, 8'h77});
      rx_valid = 1'b0;
      repeat (3) tick();
      pop_one("simempty_pop");
      check("err_cnt_unchanged", err_cnt, 2);

      // Error counter saturation
      for (int i = 0; i < 252; i++) begin
         send_byte(8'(i), 1'b1, 1'b0, 1, 1'b1);
         pop_one("sat_pop");
      end
      check("err_cnt_254", err_cnt, 254);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(i + 8'h80), 1'b0, 1'b1, 1, 1'b1);
         pop_one("sat_pop2");
      end
      check("err_cnt_sat", err_cnt, 255);

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      for (int i = 0; i < 13; i++) send_byte(8'(8'hC0 + i), 1'b0, 1'b0, 1, 1'b1);
      check("af_count13", count, 13);
      check("af_13", almost_full, 1'b0);
      send_byte(8'hCD, 1'b0, 1'b0, 1, 1'b1);
      check("af_14", almost_full, 1'b1);
      pop_one("af_pop");
      check("af_back13", almost_full, 1'b0);
      for (int i = 0; i < 13; i++) pop_one("af_drain");
`endif

      // Reset mid-operation flushes contents
      send_byte(8'h21, 1'b1, 1'b0, 2, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0, 2, 1'b0);
      check("mid_count_pre", count, 2);
      rst = 1'b0; tick(); rst = 1'b1;
      check("mid_rst_count", count, 0);
      check("mid_rst_empty", empty, 1'b1);
      check("mid_rst_errcnt", err_cnt, 0);
      check("mid_rst_rddata", rd_data, 0);
      check("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
